// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts input spikes over repeating windows of
// win_len cycles and hands each count out on a valid/ready port. An
// exponentially decaying synaptic trace of the spike input runs on
// every cycle, independent of the counting state machine.
module spike_rate_decoder #(
  parameter int unsigned W         = 32,
  parameter int unsigned F         = 16,
  parameter int unsigned CW        = 16,
  parameter int unsigned TAU_SHIFT = 4,
  parameter int unsigned K_SYN     = 65536
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spike_in,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] win_len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] rate_count,
  output logic          overrun,
  output logic [W-1:0]  trace_q,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW:0]   ONE_EXT = (CW+1)'(1);
  localparam logic [W:0]    K_EXT   = (W+1)'(K_SYN);

  // Elaboration-time sanity checks on the fixed-point configuration
  if (F > W) begin : g_bad_frac
    $error("spike_rate_decoder: F must not exceed W");
  end
  if (TAU_SHIFT >= W) begin : g_bad_tau
    $error("spike_rate_decoder: TAU_SHIFT must be smaller than W");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rate_q, rate_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_inc;
  logic [CW:0]   win_last;
  logic [W:0]    trace_sum;
  logic [W-1:0]  trace_d;

  assign out_valid  = valid_q;
  assign rate_count = rate_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

  // Window FSM, counters and result handshake next-state
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
    rate_d   = rate_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    cnt_inc  = (spike_in && (cnt_q != CNT_MAX)) ? cnt_q + CW'(1) : cnt_q;
    // win_q is never 0 in RUN; the extra bit keeps the compare wrap-free
    win_last = {1'b0, win_q} - ONE_EXT;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start && !stop && (win_len != '0)) begin
          state_d = RUN;
          win_d   = win_len;
          cyc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          cyc_d   = '0;
          cnt_d   = '0;
        end else if ({1'b0, cyc_q} == win_last) begin
          rate_d  = cnt_inc;
          valid_d = 1'b1;
          if (valid_q && !out_ready) begin
            ovr_d = 1'b1;
          end
          cyc_d = '0;
          cnt_d = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // Trace decay plus spike kick, one guard bit, saturating
  always_comb begin
    trace_sum = {1'b0, trace_q} - (W+1)'(trace_q >> TAU_SHIFT)
              + (spike_in ? K_EXT : '0);
    trace_d   = trace_sum[W] ? '1 : trace_sum[W-1:0];
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      rate_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      trace_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      trace_q <= trace_d;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios followed by random
// traffic, compared against a behavioural model. Window results flow
// through a scoreboard queue consumed by a monitor on the falling edge.
module tb_spike_rate_decoder;

  localparam int unsigned TW   = 20;
  localparam int unsigned TF   = 16;
  localparam int unsigned TCW  = 8;
  localparam int unsigned TAU  = 4;
  localparam int unsigned KSYN = 65536;
  localparam longint TMAX = (longint'(1) << TW) - 1;
  localparam int     CMAX = (1 << TCW) - 1;

  logic           clk = 1'b0;
  logic           rst, spike_in, start, stop, out_ready;
  logic [TCW-1:0] win_len;
  logic           out_valid, overrun, busy;
  logic [TCW-1:0] rate_count;
  logic [TW-1:0]  trace_q;

  spike_rate_decoder #(
    .W(TW), .F(TF), .CW(TCW), .TAU_SHIFT(TAU), .K_SYN(KSYN)
  ) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .start(start), .stop(stop),
    .win_len(win_len), .out_valid(out_valid), .out_ready(out_ready),
    .rate_count(rate_count), .overrun(overrun), .trace_q(trace_q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     run;
    int     win;
    int     pos;
    int     cnt;
    int     rate;
    bit     valid;
    bit     ovr;
    longint trace;
  } mstate_t;

  mstate_t cur, nxt;
  int      sb[$];
  int      n_checks = 0;
  int      n_errors = 0;
  bit      chk_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the next clock edge should produce
  task automatic model_next(input int wl);
    longint t;
    int     c;
    nxt = cur;
    t = cur.trace - (cur.trace >> TAU) + (spike_in ? longint'(KSYN) : 0);
    if (t > TMAX) t = TMAX;
    nxt.trace = t;
    if (rst) begin
      nxt = '{default: 0};
      if (!(cur.valid && out_ready)) sb.delete();
      return;
    end
    if (cur.valid && out_ready) nxt.valid = 1'b0;
    if (!cur.run) begin
      if (start && !stop && wl != 0) begin
        nxt.run = 1'b1;
        nxt.win = wl;
        nxt.pos = 0;
        nxt.cnt = 0;
      end
    end else if (stop) begin
      nxt.run = 1'b0;
    end else begin
      c = cur.cnt + int'(spike_in);
      if (c > CMAX) c = CMAX;
      if (cur.pos + 1 == cur.win) begin
        if (cur.valid && !out_ready) begin
          nxt.ovr = 1'b1;
          if (sb.size() > 0) void'(sb.pop_back());
        end
        sb.push_back(c);
        nxt.rate  = c;
        nxt.valid = 1'b1;
        nxt.pos   = 0;
        nxt.cnt   = 0;
      end else begin
        nxt.pos = cur.pos + 1;
        nxt.cnt = c;
      end
    end
  endtask

  // One clock: drive inputs, predict, advance to just after the edge
  task automatic cycle(input logic r, input logic s, input logic p,
                       input logic sp, input int wl, input logic rd);
    rst = r; start = s; stop = p; spike_in = sp; out_ready = rd;
    win_len = TCW'(wl);
    model_next(wl);
    @(posedge clk);
    #1;
    cur = nxt;
  endtask

  // Monitor: status every cycle, results popped on each transfer
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", longint'(busy), longint'(cur.run));
      check("out_valid", longint'(out_valid), longint'(cur.valid));
      check("overrun", longint'(overrun), longint'(cur.ovr));
      check("rate_count", longint'(rate_count), longint'(cur.rate));
      check("trace_q", longint'(trace_q), cur.trace);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          check("sb_result", longint'(rate_count), longint'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cur = '{default: 0};
    rst = 1'b1; start = 1'b0; stop = 1'b0; spike_in = 1'b0;
    out_ready = 1'b0; win_len = '0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    check("reset_busy", longint'(busy), 0);
    check("reset_valid", longint'(out_valid), 0);
    check("reset_trace", longint'(trace_q), 0);

    // Single spike from reset: trace kick then geometric decay
    cycle(0, 0, 0, 1, 0, 0);
    check("trace_kick", longint'(trace_q), 65536);
    cycle(0, 0, 0, 0, 0, 0);
    check("trace_decay1", longint'(trace_q), 61440);
    cycle(0, 0, 0, 0, 0, 0);
    check("trace_decay2", longint'(trace_q), 57600);

    // win_len 8, three spikes, consumer always ready
    cycle(0, 1, 0, 0, 8, 1);
    check("run_busy", longint'(busy), 1);
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 0, 0, (k == 2 || k == 4 || k == 7), 3, 1);
      if (k == 7) check("no_early_valid", longint'(out_valid), 0);
    end
    check("win8_valid", longint'(out_valid), 1);
    check("win8_rate", longint'(rate_count), 3);
    cycle(0, 0, 0, 0, 8, 1);
    check("win8_valid_clear", longint'(out_valid), 0);
    cycle(0, 0, 1, 0, 8, 1);

    // win_len 4, consumer stalled, continuous spikes: overwrite
    cycle(0, 1, 0, 1, 4, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 9, 0);
    check("win4_first_rate", longint'(rate_count), 4);
    check("win4_first_ovr", longint'(overrun), 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 9, 0);
    check("win4_overrun", longint'(overrun), 1);
    check("win4_valid_kept", longint'(out_valid), 1);
    check("win4_second_rate", longint'(rate_count), 4);
    cycle(0, 0, 1, 0, 4, 1);

    // win_len 6, stop on RUN cycle 5 discards the window
    cycle(0, 1, 0, 0, 6, 1);
    for (int k = 1; k <= 5; k++) cycle(0, 0, (k == 5), 1, 6, 1);
    check("stop_busy", longint'(busy), 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 6, 1);
    check("stop_no_valid", longint'(out_valid), 0);
    check("stop_rate_kept", longint'(rate_count), 4);

    // Zero window length and start+stop together are both ignored
    cycle(0, 1, 0, 0, 0, 1);
    check("zero_win_idle", longint'(busy), 0);
    cycle(0, 1, 1, 0, 5, 1);
    check("start_stop_idle", longint'(busy), 0);

    // Reset on RUN cycle 3 of an 8-cycle window
    cycle(0, 1, 0, 1, 8, 0);
    cycle(0, 0, 0, 1, 8, 0);
    cycle(0, 0, 0, 1, 8, 0);
    cycle(1, 0, 0, 1, 8, 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_rate", longint'(rate_count), 0);
    check("rst_ovr", longint'(overrun), 0);
    check("rst_trace", longint'(trace_q), 0);
    cycle(0, 1, 0, 0, 2, 0);
    cycle(0, 0, 0, 1, 2, 0);
    cycle(0, 0, 0, 1, 2, 0);
    check("post_rst_rate", longint'(rate_count), 2);
    check("post_rst_ovr", longint'(overrun), 0);
    cycle(0, 0, 1, 0, 2, 1);

    // Held spikes drive the trace into saturation
    for (int k = 0; k < 300; k++) cycle(0, 0, 0, 1, 0, 1);
    check("trace_sat", longint'(trace_q), TMAX);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(499) == 0), ($urandom_range(7) == 0),
            ($urandom_range(39) == 0), ($urandom_range(2) == 0),
            int'($urandom_range(12)), ($urandom_range(1) == 0));
    end

    // Drain outstanding results
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, 0, 1);
    check("sb_drained", longint'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning trace data width.
REQ-002 The block SHALL have parameter F, default 16, meaning trace fractional bits (Q(W-F).F, unsigned).
REQ-003 The block SHALL have parameter CW, default 16, meaning window-length and spike-count width.
REQ-004 The block SHALL have parameter TAU_SHIFT, default 4, meaning trace decay shift (decay = trace >> TAU_SHIFT per cycle).
REQ-005 The block SHALL have parameter K_SYN, default 65536, meaning trace increment per spike (1.0 in Q16.16).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port spike_in, input, 1 bit: spike from upstream neuron, sampled every clk.
REQ-009 The block SHALL have port start, input, 1 bit: begin continuous windowed counting.
REQ-010 The block SHALL have port stop, input, 1 bit: abort counting, return to IDLE.
REQ-011 The block SHALL have port win_len, input, CW bits: window length in cycles, latched on accepted start.
REQ-012 The block SHALL have port out_valid, output, 1 bit: rate_count holds an unconsumed result.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-014 The block SHALL have port rate_count, output, CW bits: spikes counted in the last completed window.
REQ-015 The block SHALL have port overrun, output, 1 bit: sticky, a result was overwritten before acceptance.
REQ-016 The block SHALL have port trace_q, output, W bits: exponential synaptic trace of spike_in.
REQ-017 The block SHALL have port busy, output, 1 bit: high in RUN state.

Function
REQ-018 The FSM SHALL have states IDLE and RUN; busy = (state == RUN).
REQ-019 In IDLE, start=1 with win_len!=0 SHALL latch win_len, clear cycle and spike counters, and enter RUN next cycle; start with win_len==0 SHALL be ignored.
REQ-020 start in RUN SHALL be ignored; win_len changes during RUN SHALL have no effect.
REQ-021 In RUN, each cycle SHALL increment the cycle counter and add spike_in to the spike counter, saturating at 2^CW-1.
REQ-022 On the RUN cycle where the cycle counter equals latched win_len-1 (capture), rate_count SHALL load the count including that cycle's spike_in, out_valid SHALL be 1 from the next cycle, and both counters SHALL restart from 0 with RUN continuing.
REQ-023 Window latency: rate_count/out_valid SHALL update exactly win_len cycles after the first RUN cycle, then every win_len cycles.
REQ-024 A result SHALL transfer when out_valid && out_ready; out_valid SHALL then clear unless a capture occurs in the same cycle.
REQ-025 Capture with out_valid=1 and out_ready=0 SHALL overwrite rate_count, keep out_valid=1 and set overrun; capture coincident with acceptance SHALL NOT set overrun.
REQ-026 overrun SHALL clear only on rst.
REQ-027 stop=1 in RUN SHALL enter IDLE next cycle, discard the partial window, and suppress a capture in that same cycle; out_valid and rate_count SHALL be unaffected.
REQ-028 stop and start asserted together in IDLE SHALL result in IDLE (stop wins).
REQ-029 trace_q SHALL update every cycle in any state: trace_next = trace_q - (trace_q >> TAU_SHIFT) + (spike_in ? K_SYN : 0), computed W+1 bits wide and saturated to 2^W-1.

Reset
REQ-030 rst SHALL force, on the next clk edge: state=IDLE, counters=0, rate_count=0, out_valid=0, overrun=0, trace_q=0, busy=0.
REQ-031 rst mid-window SHALL discard all in-flight state; no result SHALL be produced for that window.

Verification
REQ-032 win_len=8, start, spike_in high on 3 RUN cycles, out_ready=1 -> out_valid high for 1 cycle after cycle 8, rate_count=3.
REQ-033 win_len=4, out_ready=0, continuous spikes -> first result 4; second capture sets overrun=1, rate_count=4, out_valid stays 1.
REQ-034 Single spike from reset, K_SYN=65536, TAU_SHIFT=4 -> trace_q=65536, then 61440, then 57600.
REQ-035 win_len=6, stop on RUN cycle 5 -> busy=0 next cycle, no out_valid, rate_count unchanged.
REQ-036 spike_in held high with trace near 2^W-1 -> trace_q saturates at 2^W-1, never wraps.
REQ-037 rst asserted on RUN cycle 3 of win_len=8 -> all outputs 0 next cycle; subsequent start behaves as from reset.
